// File: rtl/sp_bram_fifo_pkg.sv
// Shared constants and types for the single-port BRAM FIFO controller.
package sp_bram_fifo_pkg;

    localparam int DATA_WIDTH_DEF    = 32;
    localparam int ADDRESS_WIDTH_DEF = 6;
    localparam int DEPTH             = 1 << ADDRESS_WIDTH_DEF;
    localparam int COUNT_WIDTH       = ADDRESS_WIDTH_DEF + 2;

    // Output buffer capacity; also the read-credit limit for the BRAM port.
    localparam logic [1:0] OUT_BUF_DEPTH = 2'd2;

    typedef enum logic [1:0] {
        PORT_IDLE  = 2'd0,
        PORT_WRITE = 2'd1,
        PORT_READ  = 2'd2
    } port_op_e;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/bram_fifo_out_buf.sv
// Two-entry register queue that absorbs BRAM read latency in front of the consumer.
module bram_fifo_out_buf
    import sp_bram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  append,
    input  logic [DATA_WIDTH-1:0] append_data,
    input  logic                  pop,
    output logic [1:0]            out_count,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] entry0_q, entry0_d;
    logic [DATA_WIDTH-1:0] entry1_q, entry1_d;
    logic [1:0]            count_q, count_d;
    logic                  pop_fire;

    assign pop_fire  = pop && (count_q != 2'd0);
    assign out_count = count_q;
    assign valid     = (count_q != 2'd0);
    assign head      = entry0_q;

    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        case ({append, pop_fire})
            2'b11: begin
                // Head leaves and the new word lands behind whatever remains.
                if (count_q == OUT_BUF_DEPTH) begin
                    entry0_d = entry1_q;
                    entry1_d = append_data;
                end else begin
                    entry0_d = append_data;
                end
            end
            2'b01: begin
                entry0_d = entry1_q;
                count_d  = count_q - 2'd1;
            end
            2'b10: begin
                if (count_q == 2'd0) begin
                    entry0_d = append_data;
                    count_d  = 2'd1;
                end else if (count_q == 2'd1) begin
                    entry1_d = append_data;
                    count_d  = 2'd2;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sp_bram_fifo_ctrl.sv
// Streaming FIFO built on a single-port BRAM: arbitrates one read or one write per
// cycle, with reads taking priority, and hides read latency in a 2-entry buffer.
module sp_bram_fifo_ctrl
    import sp_bram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [DATA_WIDTH-1:0]    push_data,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [DATA_WIDTH-1:0]    pop_data,
    output logic [ADDRESS_WIDTH+1:0] count,
    output logic                     mem_n_clr,
    output logic                     mem_write_en,
    output logic                     mem_read_en,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_data_in,
    input  logic [DATA_WIDTH-1:0]    mem_data_out
);

    localparam int MEM_DEPTH = fifo_depth(ADDRESS_WIDTH);
    localparam int CNT_W     = ADDRESS_WIDTH + 2;

    localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE  = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDRESS_WIDTH:0]   MC_ONE   = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDRESS_WIDTH:0]   MC_FULL  = MC_ONE << ADDRESS_WIDTH;

    logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDRESS_WIDTH:0]   mem_count_q, mem_count_d;
    logic                     rd_pending_q, rd_pending_d;

    logic [1:0] out_count;
    logic [1:0] credits_used;
    logic       mem_full;
    logic       rd_req;
    logic       wr_fire;
    port_op_e   port_op;

    // Words sitting in the buffer plus the one in flight may never exceed its capacity.
    assign credits_used = out_count + {1'b0, rd_pending_q};
    assign mem_full     = (mem_count_q == MC_FULL);
    assign rd_req       = (mem_count_q != '0) && (credits_used < OUT_BUF_DEPTH);

    assign push_ready   = !mem_full && !rd_req;
    assign wr_fire      = push_valid && push_ready && !clr;

    always_comb begin
        port_op = PORT_IDLE;
        if (rd_req) begin
            port_op = PORT_READ;
        end else if (wr_fire) begin
            port_op = PORT_WRITE;
        end
    end

    always_comb begin
        mem_addr = '0;
        case (port_op)
            PORT_WRITE: mem_addr = wr_ptr_q;
            PORT_READ:  mem_addr = rd_ptr_q;
            default:    mem_addr = '0;
        endcase
    end

    assign mem_write_en = (port_op == PORT_WRITE);
    assign mem_read_en  = (port_op == PORT_READ);
    assign mem_data_in  = push_data;
    assign mem_n_clr    = ~clr;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        mem_count_d  = mem_count_q;
        rd_pending_d = rd_req;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_req) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({wr_fire, rd_req})
            2'b10:   mem_count_d = mem_count_q + MC_ONE;
            2'b01:   mem_count_d = mem_count_q - MC_ONE;
            default: mem_count_d = mem_count_q;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_count_q  <= '0;
            rd_pending_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_count_q  <= mem_count_d;
            rd_pending_q <= rd_pending_d;
        end
    end

    // BRAM data is only captured when it answers a read issued since the last clear.
    bram_fifo_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .clk         (clk),
        .clr         (clr),
        .append      (rd_pending_q),
        .append_data (mem_data_out),
        .pop         (pop_ready),
        .out_count   (out_count),
        .valid       (pop_valid),
        .head        (pop_data)
    );

    assign count = CNT_W'(mem_count_q) + CNT_W'(rd_pending_q) + CNT_W'(out_count);

endmodule

// File: tb/tb_sp_bram_fifo_ctrl.sv
// Self-checking bench for sp_bram_fifo_ctrl with a behavioural single-port BRAM.
module tb_sp_bram_fifo_ctrl;
    import sp_bram_fifo_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 6;
    localparam int D   = 64;
    localparam int CAP = D + 2;

    logic          clk;
    logic          clr;
    logic          push_valid;
    logic          push_ready;
    logic [DW-1:0] push_data;
    logic          pop_valid;
    logic          pop_ready;
    logic [DW-1:0] pop_data;
    logic [AW+1:0] count;
    logic          mem_n_clr;
    logic          mem_write_en;
    logic          mem_read_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;

    logic [DW-1:0] bram [D];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output register keeps its last value across clr, as a real BRAM would.
    always @(posedge clk) begin
        if (mem_n_clr) begin
            if (mem_write_en) bram[mem_addr] <= mem_data_in;
            if (mem_read_en)  mem_data_out   <= bram[mem_addr];
        end
    end

    sp_bram_fifo_ctrl #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .push_valid   (push_valid),
        .push_ready   (push_ready),
        .push_data    (push_data),
        .pop_valid    (pop_valid),
        .pop_ready    (pop_ready),
        .pop_data     (pop_data),
        .count        (count),
        .mem_n_clr    (mem_n_clr),
        .mem_write_en (mem_write_en),
        .mem_read_en  (mem_read_en),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the queue of accepted words, plus how many writes and reads
    // have happened since the last clear (the nth of each lands at address n mod D).
    logic [DW-1:0] q[$];
    int            wr_n;
    int            rd_n;
    logic          last_rd;
    logic [DW-1:0] last_pop_data;

    task automatic model_reset();
        q.delete();
        wr_n = 0;
        rd_n = 0;
    endtask

    task automatic step(input logic pv, input logic [DW-1:0] pd, input logic pr,
                        output logic pushed, output logic popped);
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
        #1;
        pushed  = pv && push_ready;
        popped  = pop_valid && pr;
        last_rd = mem_read_en;
        chk("count", 64'(count), 64'(q.size()));
        chk("mem_n_clr", 64'(mem_n_clr), 64'(1));
        chk("write_en", 64'(mem_write_en), 64'(pushed));
        if (q.size() == 0) chk("empty_pop_valid", 64'(pop_valid), 64'(0));
        if (q.size() >= CAP) chk("full_push_ready", 64'(push_ready), 64'(0));
        if (mem_write_en) begin
            chk("wr_addr", 64'(mem_addr), 64'(wr_n % D));
            chk("wr_data", 64'(mem_data_in), 64'(pd));
            wr_n++;
            chk("rd_en_during_wr", 64'(mem_read_en), 64'(0));
        end else if (mem_read_en) begin
            chk("rd_addr", 64'(mem_addr), 64'(rd_n % D));
            rd_n++;
        end else begin
            chk("idle_addr", 64'(mem_addr), 64'(0));
        end
        if (popped && q.size() != 0) begin
            last_pop_data = pop_data;
            chk("pop_data", 64'(pop_data), 64'(q.pop_front()));
        end
        if (pushed) q.push_back(pd);
        @(negedge clk);
    endtask

    task automatic do_clr();
        #2;
        clr = 1'b1;
        #1;
        chk("rst_push_ready", 64'(push_ready), 64'(1));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_pop_valid", 64'(pop_valid), 64'(0));
        chk("rst_pop_data", 64'(pop_data), 64'(0));
        chk("rst_write_en", 64'(mem_write_en), 64'(0));
        chk("rst_read_en", 64'(mem_read_en), 64'(0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        chk("rst_n_clr", 64'(mem_n_clr), 64'(0));
        @(negedge clk);
        clr = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic          pv;
        logic [DW-1:0] pd;
        logic          pr;
        logic          e_prdy;
        logic          e_we;
        logic          e_re;
        logic [AW-1:0] e_addr;
        logic          e_pvld;
        logic [DW-1:0] e_pdata;
        logic [AW+1:0] e_cnt;
    } vec_t;

    vec_t tv [11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pu, po;
        int   guard;
        int   nxt;
        int   npop;
        int   pushes;
        int   gap;
        int   max_gap;

        //         pv    pd     pr   prdy  we    re    addr  pvld  pdata  cnt
        tv[0]  = '{1'b1, 32'h20, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 32'h0,  8'd0};
        tv[1]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 32'h0,  8'd1};
        tv[2]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0,  8'd1};
        tv[3]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 32'h20, 8'd1};
        tv[4]  = '{1'b1, 32'h21, 1'b1, 1'b1, 1'b1, 1'b0, 6'd1, 1'b0, 32'h0,  8'd0};
        tv[5]  = '{1'b1, 32'h22, 1'b1, 1'b0, 1'b0, 1'b1, 6'd1, 1'b0, 32'h0,  8'd1};
        tv[6]  = '{1'b1, 32'h22, 1'b1, 1'b1, 1'b1, 1'b0, 6'd2, 1'b0, 32'h0,  8'd1};
        tv[7]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 6'd2, 1'b1, 32'h21, 8'd2};
        tv[8]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0,  8'd1};
        tv[9]  = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 32'h22, 8'd1};
        tv[10] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0,  8'd0};

        clr        = 1'b0;
        push_valid = 1'b0;
        push_data  = '0;
        pop_ready  = 1'b0;
        last_rd    = 1'b0;
        last_pop_data = '0;
        model_reset();
        @(negedge clk);
        do_clr();

        // Cycle-exact latency and arbitration vectors
        for (int i = 0; i < 11; i++) begin
            push_valid = tv[i].pv;
            push_data  = tv[i].pd;
            pop_ready  = tv[i].pr;
            #1;
            chk($sformatf("vec%0d_push_ready", i), 64'(push_ready), 64'(tv[i].e_prdy));
            chk($sformatf("vec%0d_write_en", i), 64'(mem_write_en), 64'(tv[i].e_we));
            chk($sformatf("vec%0d_read_en", i), 64'(mem_read_en), 64'(tv[i].e_re));
            chk($sformatf("vec%0d_addr", i), 64'(mem_addr), 64'(tv[i].e_addr));
            chk($sformatf("vec%0d_pop_valid", i), 64'(pop_valid), 64'(tv[i].e_pvld));
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(tv[i].e_cnt));
            if (tv[i].e_pvld) chk($sformatf("vec%0d_pop_data", i), 64'(pop_data), 64'(tv[i].e_pdata));
            @(negedge clk);
        end

        push_valid = 1'b1;
        do_clr();

        // Fill to capacity with the consumer stalled
        nxt = 1;
        guard = 0;
        while (nxt <= CAP && guard < 400) begin
            step(1'b1, DW'(nxt), 1'b0, pu, po);
            if (pu) nxt++;
            guard++;
        end
        chk("fill_accepted", 64'(nxt), 64'(CAP + 1));
        for (int i = 0; i < 5; i++) begin
            step(1'b1, DW'(CAP + 1), 1'b0, pu, po);
            chk("full_held_off", 64'(pu), 64'(0));
        end
        chk("full_count", 64'(count), 64'(CAP));

        npop = 0;
        guard = 0;
        while (q.size() > 0 && guard < 400) begin
            step(1'b0, '0, 1'b1, pu, po);
            if (po) npop++;
            guard++;
        end
        chk("drain_pops", 64'(npop), 64'(CAP));
        chk("drain_last", 64'(last_pop_data), 64'(CAP));
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1, pu, po);
            chk("drained_pop_valid", 64'(pop_valid), 64'(0));
        end

        // Random duty traffic across several pointer wraps
        pushes = 0;
        npop = 0;
        guard = 0;
        while ((pushes < 200 || q.size() > 0) && guard < 5000) begin
            step((pushes < 200) && ($urandom_range(0, 1) == 1), DW'($urandom),
                 ($urandom_range(0, 1) == 1), pu, po);
            if (pu) pushes++;
            if (po) npop++;
            guard++;
        end
        chk("random_pops", 64'(npop), 64'(200));

        // Back-to-back pops from a preloaded queue
        nxt = 0;
        guard = 0;
        while (nxt < 10 && guard < 100) begin
            step(1'b1, DW'(32'h100 + nxt), 1'b0, pu, po);
            if (pu) nxt++;
            guard++;
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, pu, po);
        chk("b2b_preload_valid", 64'(pop_valid), 64'(1));
        npop = 0;
        gap = 0;
        max_gap = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, 1'b1, pu, po);
            if (po) begin
                npop++;
                gap = 0;
            end else if (npop < 10) begin
                gap++;
                if (gap > max_gap) max_gap = gap;
            end
        end
        chk("b2b_pops", 64'(npop), 64'(10));
        chk("b2b_max_gap", 64'(max_gap), 64'(1));
        chk("b2b_last", 64'(last_pop_data), 64'(32'h109));

        // Clear with words queued and a BRAM read in flight
        nxt = 0;
        guard = 0;
        while (nxt < 6 && guard < 100) begin
            step(1'b1, DW'(32'h300 + nxt), 1'b0, pu, po);
            if (pu) nxt++;
            guard++;
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, pu, po);
        step(1'b0, '0, 1'b1, pu, po);
        chk("mid_pop", 64'(po), 64'(1));
        guard = 0;
        last_rd = 1'b0;
        while (!last_rd && guard < 10) begin
            step(1'b0, '0, 1'b0, pu, po);
            guard++;
        end
        chk("mid_read_issued", 64'(last_rd), 64'(1));
        do_clr();
        step(1'b0, '0, 1'b1, pu, po);
        chk("post_clr_count", 64'(count), 64'(0));
        chk("post_clr_pop_valid", 64'(pop_valid), 64'(0));
        guard = 0;
        pu = 1'b0;
        while (!pu && guard < 20) begin
            step(1'b1, 32'hAA, 1'b1, pu, po);
            guard++;
        end
        npop = 0;
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            step(1'b0, '0, 1'b1, pu, po);
            if (po) npop++;
            guard++;
        end
        chk("post_clr_pops", 64'(npop), 64'(1));
        chk("post_clr_word", 64'(last_pop_data), 64'(32'hAA));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
